// File: rtl/div_sequencer_if.sv
// Execute-stage divide/HI-LO bundle between decode/ALU (master) and div_sequencer (slave).
// Request fields flow master->slave; status, stall and HI/LO flow back.
interface div_sequencer_if #(parameter int WIDTH = 32);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic             hilo_read;
    logic             mt_hi;
    logic             mt_lo;
    logic [WIDTH-1:0] mt_data;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, dividend, divisor, flush, hilo_read, mt_hi, mt_lo, mt_data,
        input  busy, done, stall, hi, lo
    );

    modport slave (
        input  start, dividend, divisor, flush, hilo_read, mt_hi, mt_lo, mt_data,
        output busy, done, stall, hi, lo
    );
endinterface

// File: rtl/div_sequencer.sv
// WIDTH-step restoring unsigned divider owning HI/LO; result WIDTH+1 edges after start (1 for /0).
// No backpressure on results; stall freezes upstream while any HI/LO user meets a RUN.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset_n,
    div_sequencer_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             accept;
    logic             div_zero;
    logic             last_step;
    logic             stall_i;
    logic             step_ge;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    assign accept    = (state != RUN) && bus.start && !bus.flush;
    assign div_zero  = (bus.divisor == '0);
    assign last_step = (state == RUN) && !bus.flush && (cnt == CW'(WIDTH - 1));
    assign stall_i   = (state == RUN) && (bus.start || bus.hilo_read || bus.mt_hi || bus.mt_lo);

    // One restoring step; a clear borrow out of the WIDTH+1 bit subtract means rem_sh >= divisor.
    assign rem_sh  = {rem, quo[WIDTH-1]};
    assign diff    = rem_sh - {1'b0, dvsr};
    assign step_ge = !diff[WIDTH];
    assign rem_nx  = step_ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nx  = {quo[WIDTH-2:0], step_ge};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nx = div_zero ? DONE : RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_nx = IDLE;
                end else if (cnt == CW'(WIDTH - 1)) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            rem  <= '0;
            quo  <= '0;
            dvsr <= '0;
        end else if (accept) begin
            cnt  <= '0;
            rem  <= '0;
            quo  <= bus.dividend;
            dvsr <= bus.divisor;
        end else if (state == RUN) begin
            cnt  <= cnt + 1'b1;
            rem  <= rem_nx;
            quo  <= quo_nx;
        end
    end

    // Divide results win over MTHI/MTLO landing on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (accept && div_zero) begin
            hi_q <= bus.dividend;
            lo_q <= '1;
        end else if (last_step) begin
            hi_q <= rem_nx;
            lo_q <= quo_nx;
        end else if (!stall_i) begin
            if (bus.mt_hi) hi_q <= bus.mt_data;
            if (bus.mt_lo) lo_q <= bus.mt_data;
        end
    end

    always_comb begin
        bus.busy  = (state == RUN);
        bus.done  = (state == DONE);
        bus.stall = stall_i;
        bus.hi    = hi_q;
        bus.lo    = lo_q;
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed plus randomized bench for div_sequencer against an arithmetic HI/LO model.
module tb_div_sequencer;

    localparam int W = 32;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    div_sequencer_if #(.WIDTH(W)) bus ();

    div_sequencer #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.start     = 1'b0;
        bus.flush     = 1'b0;
        bus.hilo_read = 1'b0;
        bus.mt_hi     = 1'b0;
        bus.mt_lo     = 1'b0;
    endtask

    // Issues a divide in the current (IDLE or DONE) cycle and returns in the DONE cycle.
    // kind selects a HI/LO user presented during RUN from cycle 'from': 0 none, 1 MFHI,
    // 2 MTHI, 3 MTLO, 4 another DIV; all of them must stall and be ignored.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int kind, input int from);
        int nbusy;
        bit got;
        bit req;
        nbusy = 0;
        got   = 0;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        #1;
        chk("stall_at_issue", bus.stall, 0);
        if (b == 0) begin
            m_hi = a;
            m_lo = '1;
        end else begin
            m_hi = a % b;
            m_lo = a / b;
        end
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            req = (kind != 0) && (i >= from);
            bus.hilo_read = req && (kind == 1);
            bus.mt_hi     = req && (kind == 2);
            bus.mt_lo     = req && (kind == 3);
            bus.start     = req && (kind == 4);
            bus.mt_data   = $urandom;
            bus.dividend  = $urandom;
            bus.divisor   = $urandom;
            #1;
            if (bus.done) begin
                got = 1;
            end else begin
                if (bus.busy) nbusy++;
                chk("stall_in_run", bus.stall, req);
                step();
            end
        end
        chk("done_seen", got, 1);
        chk("busy_cycles", nbusy, (b == 0) ? 0 : W);
        chk("stall_in_done", bus.stall, 0);
        chk("busy_in_done", bus.busy, 0);
        chk("lo_result", bus.lo, m_lo);
        chk("hi_result", bus.hi, m_hi);
        clear_inputs();
    endtask

    task automatic to_idle();
        step();
        chk("done_one_cycle", bus.done, 0);
        chk("busy_idle", bus.busy, 0);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int sel;

        clear_inputs();
        bus.dividend = '0;
        bus.divisor  = '0;
        bus.mt_data  = '0;
        m_hi = '0;
        m_lo = '0;

        #2;
        bus.start = 1'b1;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        bus.start = 1'b0;
        #10 reset_n = 1'b1;
        step();

        do_div(32'd100, 32'd7, 1, 0);
        to_idle();
        do_div(32'hFFFF_FFFF, 32'd1, 0, 0);
        to_idle();
        do_div(32'd5, 32'hFFFF_FFFF, 0, 0);
        to_idle();
        do_div(32'h1234, 32'd0, 0, 0);
        to_idle();

        do_div(32'd50, 32'd3, 1, 3);
        do_div(32'd9, 32'd4, 0, 0);
        to_idle();

        bus.mt_hi = 1'b1;
        bus.mt_data = 32'hAAAA;
        #1;
        chk("stall_mt_idle", bus.stall, 0);
        step();
        bus.mt_hi = 1'b0;
        m_hi = 32'hAAAA;
        chk("mthi_hi", bus.hi, m_hi);
        chk("mthi_lo", bus.lo, m_lo);

        bus.start = 1'b1;
        bus.dividend = 32'd10;
        bus.divisor = 32'd3;
        step();
        bus.start = 1'b0;
        for (int i = 1; i < 10; i++) step();
        chk("busy_before_flush", bus.busy, 1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_busy", bus.busy, 0);
        chk("flush_done", bus.done, 0);
        for (int i = 0; i < 3; i++) step();
        chk("flush_no_done", bus.done, 0);
        chk("flush_hi", bus.hi, m_hi);
        chk("flush_lo", bus.lo, m_lo);

        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.divisor = 32'd0;
        step();
        clear_inputs();
        chk("flush_start_done", bus.done, 0);
        chk("flush_start_lo", bus.lo, m_lo);

        bus.mt_hi = 1'b1;
        bus.mt_lo = 1'b1;
        bus.mt_data = 32'h5A5A_0F0F;
        step();
        clear_inputs();
        m_hi = 32'h5A5A_0F0F;
        m_lo = 32'h5A5A_0F0F;
        chk("mt_both_hi", bus.hi, m_hi);
        chk("mt_both_lo", bus.lo, m_lo);

        bus.mt_lo = 1'b1;
        bus.mt_data = 32'h1111;
        do_div(32'd77, 32'd0, 0, 0);
        to_idle();

        bus.start = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor = 32'd9;
        step();
        bus.start = 1'b0;
        for (int i = 1; i < 15; i++) step();
        reset_n = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_hi", bus.hi, m_hi);
        chk("arst_lo", bus.lo, m_lo);
        #6 reset_n = 1'b1;
        step();
        do_div(32'd8, 32'd2, 0, 0);
        to_idle();

        for (int n = 0; n < 14; n++) begin
            sel = $urandom_range(0, 5);
            a = $urandom;
            case (sel)
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = 32'd1;
                3:       b = $urandom;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            do_div(a, b, $urandom_range(0, 4), $urandom_range(0, 35));
            if ($urandom_range(0, 2) != 0) begin
                to_idle();
                if ($urandom_range(0, 1) == 1) begin
                    bus.mt_lo = 1'b1;
                    bus.mt_data = $urandom;
                    m_lo = bus.mt_data;
                    step();
                    clear_inputs();
                    chk("rand_mtlo", bus.lo, m_lo);
                end
            end
        end
        to_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
